button_conditioner: RTL

- Four-channel front end for the lock datapath. Sits between the raw `ui_in[3:0]` pins and `digital_lock`, and replaces the per-bit debounce/edge-detect chain with one block.
- Per channel: synchronises the button, debounces it with a counter, and emits a single-cycle press pulse.
- Arbitrates simultaneous presses so the lock never sees more than one button pulse in a cycle.

---
 rtl/button_conditioner.sv | 94 +++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Four-channel button front end: 2-flop sync, counter debounce, one-hot press pulse.
// Optional BUTTON_CONDITIONER_RELEASE_PULSE_EN adds a per-channel btn_release pulse output.
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               any_pulse,
  output logic               multi_press
`ifdef BUTTON_CONDITIONER_RELEASE_PULSE_EN
  ,
  output logic [NUM_BTN-1:0] btn_release
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] raw_press;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic               any_q;
  logic               multi_q, multi_d;
  logic               seen;

  always_comb begin
    level_d   = level_q;
    raw_press = '0;
    seen      = 1'b0;
    multi_d   = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) level_d[i] = sync2_q[i];
        else                     cnt_d[i]   = cnt_q[i] + CNT_W'(1);
      end
    end
    raw_press = level_d & ~level_q;
    // Two or more simultaneous qualifications suppress the pulse entirely.
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (raw_press[i]) begin
        if (seen) multi_d = 1'b1;
        seen = 1'b1;
      end
    end
    pulse_d = multi_d ? '0 : raw_press;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      multi_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      any_q   <= |pulse_d;
      multi_q <= multi_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level   = level_q;
  assign btn_pulse   = pulse_q;
  assign any_pulse   = any_q;
  assign multi_press = multi_q;

`ifdef BUTTON_CONDITIONER_RELEASE_PULSE_EN
  logic [NUM_BTN-1:0] release_q;

  always_ff @(posedge clk) begin
    if (rst) release_q <= '0;
    else     release_q <= level_q & ~level_d;
  end

  assign btn_release = release_q;
`else
  // Release edges are not tracked in this build.
`endif

endmodule
